data_island_scheduler: RTL
==========================

# data_island_scheduler

Sequences HDMI data island periods in horizontal and vertical blanking. It sits between the pixel coordinate counters and the packet-selection/TMDS-encoding path. From the current `cx`/`cy` it decides when an island can open and how many 32-pixel packets fit before the next active video. It then drives the preamble, guard-band and packet phases, plus the `packet_enable`/`packet_pixel_counter` pair consumed by packet selection.

## Interface
- `FRAME_WIDTH`, 800, total pixels per line
- `FRAME_HEIGHT`, 525, total lines per frame
- `SCREEN_START_X`, 160, first active column; columns below this are blanking
- `SCREEN_START_Y`, 45, first active line; lines below this are blanking
- `BIT_WIDTH`, 10, width of `cx`
- `BIT_HEIGHT`, 10, width of `cy`
- `MAX_PACKETS`, 18, maximum packets per island (1..18)
- `clk_pixel`  in  1  pixel clock; single clock domain
- `reset_n`  in  1  asynchronous, active-low reset
- `cx`  in  BIT_WIDTH  current pixel column
- `cy`  in  BIT_HEIGHT  current pixel line
- `data_island_preamble`  out  1  island preamble cycle
- `data_island_guard`  out  1  leading or trailing island guard band cycle
- `data_island_period`  out  1  packet payload cycle
- `packet_enable`  out  1  one-cycle pulse; the next cycle is pixel 0 of a packet
- `packet_pixel_counter`  out  5  pixel index within the current packet
- `video_field_end`  out  1  pulse when `cx==FRAME_WIDTH-1 && cy==FRAME_HEIGHT-1`
- `overrun`  out  1  one-cycle pulse when active video begins while an island is open

## Operation
- Reset: all outputs 0, state IDLE, `ctl_count` 0, packet counters 0.
- `R` is the number of cycles until the next active pixel, saturated at 1023:
  - `cy>=SCREEN_START_Y && cx<SCREEN_START_X`: `R = SCREEN_START_X-cx`.
  - `cy>=SCREEN_START_Y && cx>=SCREEN_START_X`: `R = 0` (video).
  - `cy==SCREEN_START_Y-1`: `R = FRAME_WIDTH-cx+SCREEN_START_X`.
  - Otherwise: `R = 1023`.
- `ctl_count` (saturating at 15):
  - Cleared whenever `R==0` or the state is not IDLE.
  - Increments each IDLE cycle otherwise.
- Packet count: `N = min(MAX_PACKETS, (R-35)>>5)` when `R>=35`, else 0.
  - 35 = 8 preamble + 2 + 2 guard + 12 minimum control period + 10 reserved for the video preamble/guard + 1 decision cycle.
- States:
  - **IDLE**: go to PREAMBLE when `R!=0 && ctl_count>=12 && N>=1`; latch N into `packets_left`.
  - **PREAMBLE**: 8 cycles, then LEAD_GUARD.
  - **LEAD_GUARD**: 2 cycles, then PACKET. `packet_enable` pulses on the second cycle.
  - **PACKET**: `packet_pixel_counter` runs 0..31. At 31, decrement `packets_left`:
    - If nonzero, pulse `packet_enable` in the same cycle and wrap the counter to 0.
    - Else go to TRAIL_GUARD.
  - **TRAIL_GUARD**: 2 cycles, then IDLE.
- `packet_pixel_counter` is 0 outside PACKET.
- Any non-IDLE state seeing `R==0`: pulse `overrun`, go to IDLE, all phase outputs 0 next cycle. No `packet_enable` is issued.
- `video_field_end` is independent of the FSM and fires even during reset release.

## Timing
- All outputs are registered. The decision is made in cycle t from that cycle's `cx`/`cy`; the phase outputs change at t+1.
- Exactly one of preamble/guard/period is high in any cycle; none is high in IDLE.
- `packet_enable` timing:
  - Count: N pulses per island.
  - First pulse: the last LEAD_GUARD cycle.
  - Later pulses: every 32 cycles.
  - Never in the last packet's final cycle.
- Island length is `12+32N` cycles, always followed by at least 12 IDLE cycles before the next island or the video preamble.
- Back-to-back islands in one blanking interval are permitted once `ctl_count` reaches 12 again.
- An async `reset_n` assertion mid-island clears outputs immediately. After release, operation restarts from IDLE with `ctl_count` 0.

## Structure
- Shared package `hdmi_pkg`:
  - `island_state_t` enum (IDLE, PREAMBLE, LEAD_GUARD, PACKET, TRAIL_GUARD).
  - Constants `PREAMBLE_LEN=8`, `GUARD_LEN=2`, `PACKET_LEN=32`, `MIN_CONTROL=12`, `ISLAND_OVERHEAD=35`.
- One sub-module, `cycles_to_video`: purely combinational `R` calculation with saturation, reusable by the video preamble generator.

## Test plan
- 640x480 defaults, reset released at `cx=0, cy=0`:
  - Required: first island starts after 12 control cycles, with `N=18`.
  - Required: exactly 18 `packet_enable` pulses spaced 32 apart.
  - Required: trailing guard ends; `cy=0` yields multiple islands.
- Active line at `cx=SCREEN_START_X-100` (`R=100`):
  - Required: `N=(100-35)>>5=2`, 76-cycle island, at least 12 IDLE cycles before `cx==SCREEN_START_X`.
- `R=66` at an eligible IDLE cycle:
  - Required: no island.
- `R=67` at an eligible IDLE cycle:
  - Required: `N=1`, one 44-cycle island.
- Force `cx` to `SCREEN_START_X` (active line) during PACKET:
  - Required: `overrun` high one cycle, all phase outputs 0 the next cycle, state IDLE.
- Assert `reset_n=0` in PACKET at counter 17:
  - Required: outputs 0 without a clock edge.
  - Required: after release, no island before 12 IDLE cycles.
- `cx=FRAME_WIDTH-1`, `cy=FRAME_HEIGHT-1`:
  - Required: `video_field_end` high exactly one cycle per frame.

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared HDMI scheduling types and timing constants used by the data island
// scheduler and the video preamble logic.
package hdmi_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PREAMBLE    = 3'd1,
        LEAD_GUARD  = 3'd2,
        PACKET      = 3'd3,
        TRAIL_GUARD = 3'd4
    } island_state_t;

    localparam int PREAMBLE_LEN    = 8;
    localparam int GUARD_LEN       = 2;
    localparam int PACKET_LEN      = 32;
    localparam int MIN_CONTROL     = 12;
    localparam int ISLAND_OVERHEAD = 35;
    localparam int R_MAX           = 1023;

    // Number of whole packets that still leave room for the fixed island
    // overhead before active video, clipped to the per-island maximum.
    function automatic logic [4:0] packets_that_fit(input logic [9:0] r, input int max_packets);
        int fit;
        if (32'(r) < 32'(ISLAND_OVERHEAD)) begin
            fit = 0;
        end else begin
            fit = int'((32'(r) - 32'(ISLAND_OVERHEAD)) / 32'(PACKET_LEN));
        end
        if (fit > max_packets) begin
            fit = max_packets;
        end
        return 5'(fit);
    endfunction

endpackage

// File: rtl/cycles_to_video.sv
// Combinational count of pixel clocks until the next active pixel, saturated
// at 1023; zero means the current pixel is active video.
module cycles_to_video #(
    parameter int FRAME_WIDTH    = 800,
    parameter int SCREEN_START_X = 160,
    parameter int SCREEN_START_Y = 45,
    parameter int BIT_WIDTH      = 10,
    parameter int BIT_HEIGHT     = 10
) (
    input  logic [BIT_WIDTH-1:0]  cx,
    input  logic [BIT_HEIGHT-1:0] cy,
    output logic [9:0]            cycles
);
    import hdmi_pkg::*;

    logic [31:0] cx_w;
    logic [31:0] cy_w;
    logic [31:0] raw;

    always_comb begin
        cx_w = 32'(cx);
        cy_w = 32'(cy);
        raw  = 32'(R_MAX);
        if (cy_w >= 32'(SCREEN_START_Y)) begin
            if (cx_w < 32'(SCREEN_START_X)) begin
                raw = 32'(SCREEN_START_X) - cx_w;
            end else begin
                raw = 32'd0;
            end
        end else if (cy_w == 32'(SCREEN_START_Y - 1)) begin
            // Last blanking line: the rest of this line plus the next line's porch.
            raw = 32'(FRAME_WIDTH) - cx_w + 32'(SCREEN_START_X);
        end
        cycles = (raw > 32'(R_MAX)) ? 10'(R_MAX) : raw[9:0];
    end

endmodule

// File: rtl/data_island_scheduler.sv
// Opens HDMI data islands in blanking, sizes them to the time left before
// active video and drives the preamble / guard / packet phases.
module data_island_scheduler #(
    parameter int FRAME_WIDTH    = 800,
    parameter int FRAME_HEIGHT   = 525,
    parameter int SCREEN_START_X = 160,
    parameter int SCREEN_START_Y = 45,
    parameter int BIT_WIDTH      = 10,
    parameter int BIT_HEIGHT     = 10,
    parameter int MAX_PACKETS    = 18
) (
    input  logic                  clk_pixel,
    input  logic                  reset_n,
    input  logic [BIT_WIDTH-1:0]  cx,
    input  logic [BIT_HEIGHT-1:0] cy,
    output logic                  data_island_preamble,
    output logic                  data_island_guard,
    output logic                  data_island_period,
    output logic                  packet_enable,
    output logic [4:0]            packet_pixel_counter,
    output logic                  video_field_end,
    output logic                  overrun,
    output logic [2:0]            island_state_dbg
);
    import hdmi_pkg::*;

    // Handshake: none. cx/cy are sampled every clock; every output is a
    // registered level/pulse valid for exactly the cycle it is high.

    island_state_t state_q, state_d;
    logic [2:0]    phase_q, phase_d;
    logic [4:0]    pix_q, pix_d;
    logic [4:0]    left_q, left_d;
    logic [3:0]    ctl_q, ctl_d;
    logic          preamble_q, preamble_d;
    logic          guard_q, guard_d;
    logic          period_q, period_d;
    logic          pkt_en_q, pkt_en_d;
    logic          ovr_q, ovr_d;
    logic          vfe_q, vfe_d;

    logic [9:0]    r;
    logic [4:0]    n_fit;

    cycles_to_video #(
        .FRAME_WIDTH    (FRAME_WIDTH),
        .SCREEN_START_X (SCREEN_START_X),
        .SCREEN_START_Y (SCREEN_START_Y),
        .BIT_WIDTH      (BIT_WIDTH),
        .BIT_HEIGHT     (BIT_HEIGHT)
    ) u_cycles_to_video (
        .cx     (cx),
        .cy     (cy),
        .cycles (r)
    );

    assign n_fit = packets_that_fit(r, MAX_PACKETS);

    always_comb begin
        state_d  = state_q;
        phase_d  = 3'd0;
        pix_d    = 5'd0;
        left_d   = left_q;
        ctl_d    = 4'd0;
        pkt_en_d = 1'b0;
        ovr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (r != 10'd0) begin
                    ctl_d = (ctl_q == 4'd15) ? 4'd15 : ctl_q + 4'd1;
                    if ((ctl_q >= 4'(MIN_CONTROL)) && (n_fit != 5'd0)) begin
                        state_d = PREAMBLE;
                        left_d  = n_fit;
                    end
                end
            end
            PREAMBLE: begin
                if (phase_q == 3'(PREAMBLE_LEN - 1)) begin
                    state_d = LEAD_GUARD;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            LEAD_GUARD: begin
                if (phase_q == 3'(GUARD_LEN - 1)) begin
                    state_d = PACKET;
                end else begin
                    phase_d  = phase_q + 3'd1;
                    pkt_en_d = (phase_d == 3'(GUARD_LEN - 1));
                end
            end
            PACKET: begin
                if (pix_q == 5'(PACKET_LEN - 1)) begin
                    left_d = left_q - 5'd1;
                    if (left_q == 5'd1) begin
                        state_d = TRAIL_GUARD;
                    end
                end else begin
                    pix_d = pix_q + 5'd1;
                    // Announce the next packet during the final pixel of this one.
                    pkt_en_d = (pix_d == 5'(PACKET_LEN - 1)) && (left_q > 5'd1);
                end
            end
            TRAIL_GUARD: begin
                if (phase_q == 3'(GUARD_LEN - 1)) begin
                    state_d = IDLE;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Video arriving mid-island abandons the island outright.
        if ((state_q != IDLE) && (r == 10'd0)) begin
            state_d  = IDLE;
            phase_d  = 3'd0;
            pix_d    = 5'd0;
            left_d   = 5'd0;
            pkt_en_d = 1'b0;
            ovr_d    = 1'b1;
        end

        preamble_d = (state_d == PREAMBLE);
        guard_d    = (state_d == LEAD_GUARD) || (state_d == TRAIL_GUARD);
        period_d   = (state_d == PACKET);
        vfe_d      = (32'(cx) == 32'(FRAME_WIDTH - 1)) && (32'(cy) == 32'(FRAME_HEIGHT - 1));
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            phase_q    <= 3'd0;
            pix_q      <= 5'd0;
            left_q     <= 5'd0;
            ctl_q      <= 4'd0;
            preamble_q <= 1'b0;
            guard_q    <= 1'b0;
            period_q   <= 1'b0;
            pkt_en_q   <= 1'b0;
            ovr_q      <= 1'b0;
            vfe_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            pix_q      <= pix_d;
            left_q     <= left_d;
            ctl_q      <= ctl_d;
            preamble_q <= preamble_d;
            guard_q    <= guard_d;
            period_q   <= period_d;
            pkt_en_q   <= pkt_en_d;
            ovr_q      <= ovr_d;
            vfe_q      <= vfe_d;
        end
    end

    assign data_island_preamble = preamble_q;
    assign data_island_guard    = guard_q;
    assign data_island_period   = period_q;
    assign packet_enable        = pkt_en_q;
    assign packet_pixel_counter = pix_q;
    assign video_field_end      = vfe_q;
    assign overrun              = ovr_q;
    assign island_state_dbg     = state_q;

endmodule
